// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 initiator for 16-bit {rw, addr[6:0], data[7:0]} frames, MSB first.
// Programmable SCLK half-period and inter-frame nCS gap; CIPO is captured on each SCLK fall.
`default_nettype none

module spi_controller #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       SCLK,
  output logic       nCS,
  output logic       COPI,
  input  logic       CIPO
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  bits_q, bits_d;
  logic [15:0] shift_q, shift_d;
  logic [7:0]  cap_q, cap_d;
  logic [1:0]  sync_q;
  logic        sclk_q, sclk_d;
  logic        ncs_q, ncs_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        phase_done;

  assign phase_done = (cnt_q == 16'(CLK_DIV - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 16'd1;
    bits_d      = bits_q;
    shift_d     = shift_q;
    cap_d       = cap_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cmd_valid) begin
          state_d = SETUP;
          shift_d = {cmd_rw, cmd_addr, cmd_data};
          bits_d  = '0;
        end
      end
      SETUP: begin
        if (phase_done) begin
          state_d = HIGH;
          cnt_d   = '0;
        end
      end
      HIGH: begin
        if (phase_done) begin
          // Falling edge: advance COPI (zero fill leaves COPI low after bit 0) and sample CIPO.
          state_d = LOW;
          cnt_d   = '0;
          bits_d  = bits_q + 5'd1;
          shift_d = {shift_q[14:0], 1'b0};
          cap_d   = {cap_q[6:0], sync_q[1]};
        end
      end
      LOW: begin
        if (phase_done) begin
          cnt_d = '0;
          if (bits_q == 5'd16) begin
            state_d     = GAP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = cap_q;
          end else begin
            state_d = HIGH;
          end
        end
      end
      GAP: begin
        // cmd_ready is registered one cycle ahead of the next accept, so leaving
        // GAP after CS_GAP-1 cycles keeps nCS high exactly CS_GAP cycles back-to-back.
        if (cnt_q == 16'(CS_GAP - 2)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    sclk_d  = (state_d == HIGH);
    ncs_d   = (state_d == IDLE) || (state_d == GAP);
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bits_q      <= '0;
      shift_q     <= '0;
      cap_q       <= '0;
      sync_q      <= '0;
      sclk_q      <= 1'b0;
      ncs_q       <= 1'b1;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bits_q      <= bits_d;
      shift_q     <= shift_d;
      cap_q       <= cap_d;
      sync_q      <= {sync_q[0], CIPO};
      sclk_q      <= sclk_d;
      ncs_q       <= ncs_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign SCLK      = sclk_q;
  assign nCS       = ncs_q;
  assign COPI      = shift_q[15];
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_controller.sv
// tb_spi_controller: randomized scoreboard bench for spi_controller with an SPI peripheral model.
// The peripheral decodes frames from the pins, serves CIPO bytes and keeps a 128-entry register file.
`default_nettype none

module tb_spi_controller;
  localparam int CLK_DIV = 4;
  localparam int CS_GAP  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_rw = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_data = '0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       SCLK;
  logic       nCS;
  logic       COPI;
  logic       CIPO = 1'b0;

  spi_controller #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .SCLK(SCLK), .nCS(nCS), .COPI(COPI), .CIPO(CIPO)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [15:0] exp_frame_q[$];
  logic [7:0]  exp_byte_q[$];
  logic [7:0]  cipo_q[$];
  logic [15:0] obs_q[$];
  logic [7:0]  exp_regs[128];
  logic [7:0]  per_regs[128];
  int          issued = 0;
  int          started = 0;

  // Peripheral-side view of the bus
  int          rises = 0, falls = 0, t0 = 0, gap_cnt = 0, last_gap = 0;
  logic [15:0] rx = '0;
  logic [7:0]  cur = '0;
  bit          rise_ok = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Peripheral model plus response monitor, sampled on the falling clk edge.
  initial begin : slave_monitor
    logic p_ncs, p_sclk, p_rsp;
    logic [15:0] f, o;
    logic [7:0]  b;
    int idx;
    p_ncs = 1'b1; p_sclk = 1'b0; p_rsp = 1'b0;
    forever begin
      @(negedge clk);
      if (p_ncs && !nCS) begin
        started++;
        last_gap = gap_cnt;
        cur = (cipo_q.size() != 0) ? cipo_q.pop_front() : 8'h00;
        rises = 0; falls = 0; rx = '0; t0 = cyc; rise_ok = 1'b1;
        CIPO = 1'($urandom);
      end else if (!p_ncs && nCS) begin
        gap_cnt = 1;
        if (rises == 16) begin
          chk("ncs_low_cycles", cyc - t0, 33 * CLK_DIV);
          chk("sclk_rise_timing", {31'd0, rise_ok}, 1);
          if (rx[15]) per_regs[rx[14:8]] = rx[7:0];
          obs_q.push_back(rx);
        end
        CIPO = 1'b0;
      end else if (nCS) begin
        gap_cnt++;
      end
      if (!nCS) begin
        if (!p_sclk && SCLK) begin
          rises++;
          rx = {rx[14:0], COPI};
          if (rises > 16 || (cyc - t0) != CLK_DIV * (2 * rises - 1)) rise_ok = 1'b0;
        end
        if (p_sclk && !SCLK) begin
          falls++;
          if (falls < 16) begin
            idx = 15 - falls;
            CIPO = (idx <= 7) ? cur[idx] : 1'($urandom);
          end
        end
      end
      if (rsp_valid) begin
        if (exp_frame_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_rsp actual=rsp_data 0x%0h required=no response", rsp_data);
        end else begin
          f = exp_frame_q.pop_front();
          b = exp_byte_q.pop_front();
          o = (obs_q.size() != 0) ? obs_q.pop_front() : 16'hxxxx;
          chk("copi_frame", o, f);
          chk("rsp_data", rsp_data, b);
        end
        if (p_rsp) begin
          checks++; failures++;
          $display("FAIL rsp_pulse_width actual=2+ cycles required=1 cycle");
        end
      end
      p_ncs = nCS; p_sclk = SCLK; p_rsp = rsp_valid;
    end
  end

  task automatic issue(input logic [15:0] f, input bit hold, input bit use_b, input logic [7:0] bv);
    int n;
    logic [7:0] b;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++; failures++;
      $display("FAIL issue_timeout actual=cmd_ready 0 required=1");
    end
    b = use_b ? bv : 8'($urandom);
    exp_frame_q.push_back(f);
    exp_byte_q.push_back(b);
    cipo_q.push_back(b);
    if (f[15]) exp_regs[f[14:8]] = f[7:0];
    issued++;
    cmd_valid = 1'b1;
    {cmd_rw, cmd_addr, cmd_data} = f;
    @(posedge clk);
    #1;
    if (!hold) begin
      cmd_valid = 1'b0;
      {cmd_rw, cmd_addr, cmd_data} = 16'($urandom);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_frame_q.size() != 0 || !cmd_ready) && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_frame_q.size() != 0 || !cmd_ready) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=%0d pending required=0", exp_frame_q.size());
    end
  endtask

  initial begin : main
    int act, n, bad;
    logic [7:0] saved;
    logic [15:0] f;
    bit hold;
    for (int i = 0; i < 128; i++) begin
      exp_regs[i] = 8'h00;
      per_regs[i] = 8'h00;
    end

    repeat (3) @(negedge clk);
    chk("rst_ncs", {31'd0, nCS}, 1);
    chk("rst_sclk", {31'd0, SCLK}, 0);
    chk("rst_copi", {31'd0, COPI}, 0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_rsp_data", {24'd0, rsp_data}, 0);
    rst_n = 1'b1;
    act = 0;
    repeat (20) begin
      @(negedge clk);
      if (SCLK || !nCS) act++;
    end
    chk("idle_no_sclk", act, 0);

    issue(16'h8480, 1'b0, 1'b0, 8'h00);
    wait_done();
    chk("pwm_reg_write", {24'd0, per_regs[4]}, 32'h80);

    issue(16'h0400, 1'b0, 1'b1, 8'hA5);
    wait_done();

    issue(16'h80FF, 1'b1, 1'b0, 8'h00);
    issue(16'h810F, 1'b0, 1'b0, 8'h00);
    wait_done();
    chk("b2b_cs_gap", last_gap, CS_GAP);
    chk("en_reg_7_0", {24'd0, per_regs[0]}, 32'hFF);
    chk("en_reg_15_8", {24'd0, per_regs[1]}, 32'h0F);

    // Disturb the cmd_* inputs mid-frame; only the latched word may be sent.
    issue(16'h8A5A, 1'b0, 1'b0, 8'h00);
    repeat (30) @(negedge clk);
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 7'h0A; cmd_data = 8'hC3;
    repeat (10) @(negedge clk);
    cmd_valid = 1'b0;
    wait_done();
    repeat (200) @(negedge clk);
    chk("no_extra_frame", started, issued);

    saved = exp_regs[3];
    issue(16'h8355, 1'b0, 1'b0, 8'h00);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (rises < 8 && n < 1000);
    chk("reach_8th_rise", rises, 8);
    rst_n = 1'b0;
    #1;
    chk("midrst_ncs", {31'd0, nCS}, 1);
    chk("midrst_sclk", {31'd0, SCLK}, 0);
    chk("midrst_copi", {31'd0, COPI}, 0);
    chk("midrst_cmd_ready", {31'd0, cmd_ready}, 1);
    exp_frame_q.delete();
    exp_byte_q.delete();
    cipo_q.delete();
    exp_regs[3] = saved;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_reg_unchanged", {24'd0, per_regs[3]}, {24'd0, saved});
    issue(16'h823C, 1'b0, 1'b0, 8'h00);
    wait_done();
    chk("post_rst_write", {24'd0, per_regs[2]}, 32'h3C);

    for (int k = 0; k < 24; k++) begin
      f = 16'($urandom);
      hold = (k != 23) && ($urandom_range(0, 2) == 0);
      issue(f, hold, 1'b0, 8'h00);
      if (!hold) begin
        wait_done();
        repeat ($urandom_range(0, 20)) @(negedge clk);
      end
    end
    wait_done();
    repeat (50) @(negedge clk);

    bad = 0;
    for (int i = 0; i < 128; i++) if (per_regs[i] !== exp_regs[i]) bad++;
    chk("reg_file_match", bad, 0);
    chk("frames_started", started, issued);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
